// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator for a raster pixel stream, using two external line memories
// that hold the two previous rows of the frame.
module window_gen_3x3 #(
  parameter int unsigned WIDTH  = 1920,
  parameter int unsigned HEIGHT = 1080
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic [7:0]  i_data,
  output logic        o_mem0_en,
  output logic        o_mem1_en,
  output logic [10:0] o_mem0_addr,
  output logic [10:0] o_mem1_addr,
  output logic [7:0]  o_mem0_data,
  output logic [7:0]  o_mem1_data,
  input  logic [7:0]  i_mem0_data,
  input  logic [7:0]  i_mem1_data,
  output logic        o_valid,
  output logic [71:0] o_win,
  output logic [10:0] o_x,
  output logic [10:0] o_y,
  output logic        o_frame_done
);

  localparam logic [10:0] XLast = 11'(WIDTH - 1);
  localparam logic [10:0] YLast = 11'(HEIGHT - 1);

  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] cur_x, cur_y;
  logic [71:0] win_q, win_d;
  logic [71:0] owin_q;
  logic [10:0] ox_q, oy_q;
  logic        valid_q, done_q;
  logic        accept, win_ok, last_px;

  assign accept = i_valid & ~rst;

  always_comb begin
    // Start of frame overrides whatever position the counters hold.
    cur_x = i_sof ? 11'd0 : x_q;
    cur_y = i_sof ? 11'd0 : y_q;

    x_d = x_q;
    y_d = y_q;
    if (accept) begin
      if (cur_x == XLast) begin
        x_d = 11'd0;
        y_d = (cur_y == YLast) ? 11'd0 : cur_y + 11'd1;
      end else begin
        x_d = cur_x + 11'd1;
        y_d = cur_y;
      end
    end

    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[24*r +: 8]     = win_q[24*r + 8 +: 8];
        win_d[24*r + 8 +: 8] = win_q[24*r + 16 +: 8];
      end
      win_d[16 +: 8] = i_mem1_data;
      win_d[40 +: 8] = i_mem0_data;
      win_d[64 +: 8] = i_data;
    end

    win_ok  = accept && (cur_x >= 11'd2) && (cur_y >= 11'd2);
    last_px = accept && (cur_x == XLast) && (cur_y == YLast);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      win_q   <= '0;
      owin_q  <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      win_q   <= win_d;
      valid_q <= win_ok;
      done_q  <= last_px;
      if (win_ok) begin
        owin_q <= win_d;
        ox_q   <= cur_x - 11'd1;
        oy_q   <= cur_y - 11'd1;
      end
    end
  end

  // Memory 0 holds row y-1; its old contents cascade into memory 1 as row y-2.
  assign o_mem0_en    = accept;
  assign o_mem1_en    = accept;
  assign o_mem0_addr  = cur_x;
  assign o_mem1_addr  = cur_x;
  assign o_mem0_data  = i_data;
  assign o_mem1_data  = i_mem0_data;

  assign o_valid      = valid_q;
  assign o_win        = owin_q;
  assign o_x          = ox_q;
  assign o_y          = oy_q;
  assign o_frame_done = done_q;

endmodule
